// File: rtl/inc_dec_unit.sv
// inc_dec_unit: +b / -b step primitive built from explicit ripple carry and
// borrow chains, plus a registered up/down counter that steps its own state
// through a second, independent pair of chains.

// One bit-sliced increment chain and one decrement chain sharing the step input.
module inc_dec_chain #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    output logic [WIDTH-1:0] inc_res,
    output logic             inc_carry,
    output logic [WIDTH-1:0] dec_res,
    output logic             dec_borrow
);

    logic [WIDTH:0] carry_s;
    logic [WIDTH:0] borrow_s;

    assign carry_s[0]  = b;
    assign borrow_s[0] = b;

    // Half-adder and half-subtractor per bit; carry/borrow ripple upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign inc_res[i]      = a[i] ^ carry_s[i];
        assign carry_s[i + 1]  = a[i] & carry_s[i];
        assign dec_res[i]      = a[i] ^ borrow_s[i];
        assign borrow_s[i + 1] = ~a[i] & borrow_s[i];
    end

    assign inc_carry  = carry_s[WIDTH];
    assign dec_borrow = borrow_s[WIDTH];

endmodule

module inc_dec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    output logic [WIDTH-1:0] inc_res,
    output logic             inc_carry,
    output logic [WIDTH-1:0] dec_res,
    output logic             dec_borrow,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_r;
    logic             wrap_r;
    logic [WIDTH-1:0] cnt_next_s;
    logic             wrap_next_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             cnt_carry_s;
    logic [WIDTH-1:0] cnt_dec_s;
    logic             cnt_borrow_s;

    // Operand path: purely combinational, no dependency on clk or rst_n.
    inc_dec_chain #(.WIDTH(WIDTH)) u_op_chain (
        .a          (a),
        .b          (b),
        .inc_res    (inc_res),
        .inc_carry  (inc_carry),
        .dec_res    (dec_res),
        .dec_borrow (dec_borrow)
    );

    // Counter path: its own chains so a/b can never disturb the count.
    inc_dec_chain #(.WIDTH(WIDTH)) u_cnt_chain (
        .a          (cnt_r),
        .b          (1'b1),
        .inc_res    (cnt_inc_s),
        .inc_carry  (cnt_carry_s),
        .dec_res    (cnt_dec_s),
        .dec_borrow (cnt_borrow_s)
    );

    // Next counter state: load beats stepping; wrap flags only a wrapping step.
    always_comb begin
        cnt_next_s  = cnt_r;
        wrap_next_s = 1'b0;
        if (load) begin
            cnt_next_s  = load_val;
            wrap_next_s = 1'b0;
        end else if (en) begin
            if (up) begin
                cnt_next_s  = cnt_inc_s;
                wrap_next_s = cnt_carry_s;
            end else begin
                cnt_next_s  = cnt_dec_s;
                wrap_next_s = cnt_borrow_s;
            end
        end else begin
            cnt_next_s  = cnt_r;
            wrap_next_s = 1'b0;
        end
    end

    // Counter state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign cnt  = cnt_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_inc_dec_unit.sv
// Directed and random checks of inc_dec_unit at WIDTH=16, plus an
// exhaustive sweep of a WIDTH=4 instance's operand chains.
module tb_inc_dec_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic        b;
    logic [15:0] inc_res;
    logic        inc_carry;
    logic [15:0] dec_res;
    logic        dec_borrow;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] cnt;
    logic        wrap;

    logic [3:0]  a4;
    logic        b4;
    logic [3:0]  inc_res4;
    logic        inc_carry4;
    logic [3:0]  dec_res4;
    logic        dec_borrow4;
    logic [3:0]  cnt4;
    logic        wrap4;

    int passes;
    int total;

    inc_dec_unit #(.WIDTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .inc_res    (inc_res),
        .inc_carry  (inc_carry),
        .dec_res    (dec_res),
        .dec_borrow (dec_borrow),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .up         (up),
        .cnt        (cnt),
        .wrap       (wrap)
    );

    inc_dec_unit #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a4),
        .b          (b4),
        .inc_res    (inc_res4),
        .inc_carry  (inc_carry4),
        .dec_res    (dec_res4),
        .dec_borrow (dec_borrow4),
        .load       (1'b0),
        .load_val   (4'h0),
        .en         (1'b0),
        .up         (1'b0),
        .cnt        (cnt4),
        .wrap       (wrap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic comb_vec(input string tag, input logic [15:0] av, input logic bv,
                            input logic [15:0] ei, input logic ec,
                            input logic [15:0] ed, input logic eb);
        a = av;
        b = bv;
        #1;
        check({tag, ".inc_res"},    {16'h0, inc_res},    {16'h0, ei});
        check({tag, ".inc_carry"},  {31'h0, inc_carry},  {31'h0, ec});
        check({tag, ".dec_res"},    {16'h0, dec_res},    {16'h0, ed});
        check({tag, ".dec_borrow"}, {31'h0, dec_borrow}, {31'h0, eb});
    endtask

    task automatic cnt_chk(input string tag, input logic [15:0] ec, input logic ew);
        check({tag, ".cnt"},  {16'h0, cnt},  {16'h0, ec});
        check({tag, ".wrap"}, {31'h0, wrap}, {31'h0, ew});
    endtask

    initial begin
        logic [16:0] sum;
        logic [16:0] dif;
        logic [4:0]  sum4;
        logic [4:0]  dif4;
        passes   = 0;
        total    = 0;
        rst_n    = 1'b0;
        a        = 16'h0000;
        b        = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        en       = 1'b0;
        up       = 1'b0;
        a4       = 4'h0;
        b4       = 1'b0;
        #2;
        cnt_chk("reset", 16'h0000, 1'b0);

        // Directed combinational vectors.
        comb_vec("v56AC", 16'h56AC, 1'b1, 16'h56AD, 1'b0, 16'h56AB, 1'b0);
        comb_vec("v7FFF", 16'h7FFF, 1'b1, 16'h8000, 1'b0, 16'h7FFE, 1'b0);
        comb_vec("v2880", 16'h2880, 1'b1, 16'h2881, 1'b0, 16'h287F, 1'b0);
        comb_vec("vA1AF", 16'hA1AF, 1'b1, 16'hA1B0, 1'b0, 16'hA1AE, 1'b0);
        comb_vec("v0000", 16'h0000, 1'b1, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        comb_vec("vFFFF", 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 1'b0);
        comb_vec("b0_FFFF", 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
        comb_vec("b0_0000", 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        comb_vec("b0_3C5A", 16'h3C5A, 1'b0, 16'h3C5A, 1'b0, 16'h3C5A, 1'b0);

        // Counter: load a value, then clear it asynchronously mid-cycle.
        @(posedge clk); #1;
        rst_n    = 1'b1;
        load     = 1'b1;
        load_val = 16'h1234;
        @(posedge clk); #1;
        cnt_chk("load1234", 16'h1234, 1'b0);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        cnt_chk("async_rst", 16'h0000, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b0;
        a     = 16'hFFFF;
        b     = 1'b1;
        @(posedge clk); #1;
        cnt_chk("down_wrap", 16'hFFFF, 1'b1);
        en = 1'b0;
        @(posedge clk); #1;
        cnt_chk("hold", 16'hFFFF, 1'b0);

        // Load beats enable, then count up through the wrap.
        load     = 1'b1;
        load_val = 16'hFFFE;
        en       = 1'b1;
        up       = 1'b1;
        @(posedge clk); #1;
        cnt_chk("load_wins", 16'hFFFE, 1'b0);
        load = 1'b0;
        @(posedge clk); #1;
        cnt_chk("up1", 16'hFFFF, 1'b0);
        @(posedge clk); #1;
        cnt_chk("up_wrap", 16'h0000, 1'b1);
        @(posedge clk); #1;
        cnt_chk("up_after", 16'h0001, 1'b0);
        up = 1'b0;
        @(posedge clk); #1;
        cnt_chk("down1", 16'h0000, 1'b0);
        en = 1'b0;

        // Random operand vectors against an arithmetic model.
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 1'($urandom_range(0, 1));
            #1;
            sum = {1'b0, a} + {16'h0000, b};
            dif = {1'b0, a} - {16'h0000, b};
            check($sformatf("rnd%0d.inc", i),  {15'h0, inc_carry, inc_res},  {15'h0, sum});
            check($sformatf("rnd%0d.dec", i),  {15'h0, dec_borrow, dec_res}, {15'h0, dif});
        end

        // Exhaustive WIDTH=4 operand sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 2; j++) begin
                a4 = 4'(i);
                b4 = 1'(j);
                #1;
                sum4 = {1'b0, a4} + {4'h0, b4};
                dif4 = {1'b0, a4} - {4'h0, b4};
                check($sformatf("w4_%0d_%0d.inc", i, j), {27'h0, inc_carry4, inc_res4},  {27'h0, sum4});
                check($sformatf("w4_%0d_%0d.dec", i, j), {27'h0, dec_borrow4, dec_res4}, {27'h0, dif4});
            end
        end
        check("w4_cnt", {27'h0, wrap4, cnt4}, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
